// File: rtl/decoder38_pkg.sv
`default_nettype none
//==============================================================================
// Module      : decoder38_pkg
// Description : Shared types, constants and index-search helpers for the
//               scanning 3-to-8 decoder.
// Revision    : 1.0 - initial release
//==============================================================================
package decoder38_pkg;

    // Operating modes of the scanning decoder
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DIRECT = 2'd2
    } state_e;

    // Explicit-width state encodings used by the FSM register
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DIRECT = 2'd2;

    // Active-low output pattern with no digit selected
    localparam logic [7:0] OUT_OFF = 8'hFF;

    // Next set bit after idx, searching idx+1 .. idx+8 modulo 8. The final
    // candidate is idx itself, so a single-bit mask re-selects its own index.
    // Scanning from the farthest candidate inwards leaves the nearest hit.
    function automatic logic [2:0] next_set_idx(input logic [7:0] mask,
                                                input logic [2:0] idx);
        logic [2:0] res;
        logic [2:0] cand;
        res = idx;
        for (int k = 8; k >= 1; k--) begin
            cand = idx + 3'(k);
            if (mask[cand]) begin
                res = cand;
            end
        end
        return res;
    endfunction

    // Lowest set bit of mask, 0 when the mask is empty
    function automatic logic [2:0] lowest_set_idx(input logic [7:0] mask);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage : decoder38_pkg
`default_nettype wire

// File: rtl/decoder38.sv
`default_nettype none
//==============================================================================
// Module      : decoder38
// Description : Combinational 3-to-8 decoder, active-low one-hot output.
//               A low enable forces every output inactive.
// Revision    : 1.0 - initial release
//==============================================================================
module decoder38
    import decoder38_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic       en_i,
    output logic [7:0] data_o
);

    // Single shifted bit guarantees at most one low output
    assign data_o = en_i ? ~(8'b1 << code_i) : OUT_OFF;

endmodule : decoder38
`default_nettype wire

// File: rtl/decoder38_scan.sv
`default_nettype none
//==============================================================================
// Module      : decoder38_scan
// Description : Registered 3-to-8 digit-select decoder with an active-low
//               block enable. Scan mode rotates through the masked positions
//               at a prescaled rate; direct mode decodes an external code.
// Revision    : 1.0 - initial release
//==============================================================================
module decoder38_scan
    import decoder38_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int DIV_W = 17
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEI,
    input  logic       iMode,
    input  logic [2:0] iCode,
    input  logic [7:0] iMask,
    output logic [7:0] oData,
    output logic [2:0] oCode,
    output logic       oEO,
    output logic       oFrame
);

    localparam logic [DIV_W-1:0] C_CNT_MAX = DIV_W'(DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [2:0]       code_q,  code_d;
    logic             frame_q, frame_d;
    logic [7:0]       data_q;
    logic             eo_q;

    logic [2:0]       dec_code_w;
    logic             dec_en_w;
    logic [7:0]       dec_data_w;

    // Next-state, prescaler, scan index and decode selection. The mode
    // requested this cycle always wins over a pending prescaler tick.
    always_comb begin
        state_d    = iEI ? ST_IDLE : (iMode ? ST_DIRECT : ST_SCAN);
        cnt_d      = '0;
        idx_d      = idx_q;
        code_d     = code_q;
        frame_d    = 1'b0;
        dec_code_w = idx_q;
        dec_en_w   = 1'b0;
        case (state_d)
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    // Fresh entry: restart the dwell on the first enabled digit
                    idx_d = lowest_set_idx(iMask);
                end else if (cnt_q == C_CNT_MAX) begin
                    // Empty mask keeps the index parked and raises no frame
                    if (iMask != 8'h00) begin
                        idx_d   = next_set_idx(iMask, idx_q);
                        frame_d = (idx_d <= idx_q);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                code_d     = idx_d;
                dec_code_w = idx_d;
                dec_en_w   = iMask[idx_d];
            end
            ST_DIRECT: begin
                code_d     = iCode;
                dec_code_w = iCode;
                dec_en_w   = iMask[iCode];
            end
            default: begin
                // IDLE: outputs blank, index and code keep their last values
            end
        endcase
    end

    decoder38 u_dec (
        .code_i (dec_code_w),
        .en_i   (dec_en_w),
        .data_o (dec_data_w)
    );

    // State and output register stage; oEO is derived from the same decode
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            code_q  <= 3'd0;
            frame_q <= 1'b0;
            data_q  <= OUT_OFF;
            eo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            frame_q <= frame_d;
            data_q  <= dec_data_w;
            eo_q    <= &dec_data_w;
        end
    end

    assign oData  = data_q;
    assign oCode  = code_q;
    assign oEO    = eo_q;
    assign oFrame = frame_q;

endmodule : decoder38_scan
`default_nettype wire

// File: tb/tb_decoder38_scan.sv
`default_nettype none
//==============================================================================
// Module      : tb_decoder38_scan
// Description : Self-checking bench for decoder38_scan with DIV=4: a vector
//               table for reset/direct/idle behaviour plus directed scan
//               sequences for the multi-cycle corner cases.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_decoder38_scan;

    localparam int DIV   = 4;
    localparam int DIV_W = 3;

    logic       clk = 1'b0;
    logic       rst_r;
    logic       ei_r;
    logic       mode_r;
    logic [2:0] code_r;
    logic [7:0] mask_r;
    logic [7:0] oData;
    logic [2:0] oCode;
    logic       oEO;
    logic       oFrame;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       rst;
        logic       ei;
        logic       mode;
        logic [2:0] code;
        logic [7:0] mask;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       ee;
        logic       ef;
    } vec_t;

    vec_t tbl [13];

    decoder38_scan #(.DIV(DIV), .DIV_W(DIV_W)) dut (
        .iClk   (clk),
        .iRst   (rst_r),
        .iEI    (ei_r),
        .iMode  (mode_r),
        .iCode  (code_r),
        .iMask  (mask_r),
        .oData  (oData),
        .oCode  (oCode),
        .oEO    (oEO),
        .oFrame (oFrame)
    );

    always #5 clk = ~clk;

    // Output invariants: one low bit at most, oEO consistent with oData
    always @(negedge clk) begin
        n_checks++;
        if (oEO !== &oData || $countones(~oData) > 1) begin
            n_err++;
            $display("FAIL invariant: got data=%h eo=%b, want <=1 low bit and eo=&data", oData, oEO);
        end
    end

    task automatic step(input logic rst, input logic ei, input logic mode,
                        input logic [2:0] code, input logic [7:0] mask);
        rst_r  = rst;
        ei_r   = ei;
        mode_r = mode;
        code_r = code;
        mask_r = mask;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] ed, input logic [2:0] ec,
                       input logic ee, input logic ef);
        n_checks++;
        if (oData !== ed || oCode !== ec || oEO !== ee || oFrame !== ef) begin
            n_err++;
            $display("FAIL %s: got data=%h code=%0d eo=%b frame=%b, want data=%h code=%0d eo=%b frame=%b",
                     name, oData, oCode, oEO, oFrame, ed, ec, ee, ef);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("reset", 8'hFF, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [2:0] idx;
        logic [7:0] one;
        logic       ef;
        logic [2:0] pos [3];

        rst_r  = 1'b1;
        ei_r   = 1'b0;
        mode_r = 1'b0;
        code_r = 3'd0;
        mask_r = 8'hFF;

        // rst ei mode code mask | data code eo frame
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd5, 8'hFF, 8'hDF, 3'd5, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd3, 8'hF7, 8'hFF, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 8'h7F, 3'd7, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'd2, 8'hFF, 8'hFF, 3'd7, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 3'd6, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd6, 8'hFF, 8'hBF, 3'd6, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 3'd6, 8'hBF, 8'hFF, 3'd6, 1'b1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].ei, tbl[i].mode, tbl[i].code, tbl[i].mask);
            chk($sformatf("table[%0d]", i), tbl[i].ed, tbl[i].ec, tbl[i].ee, tbl[i].ef);
        end

        // Full scan: each digit dwells 4 cycles, frame on return to digit 0
        do_reset();
        for (int t = 0; t < 36; t++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
            idx = 3'((t / 4) % 8);
            one = 8'b1 << idx;
            ef  = (t % 4 == 0) && (t > 0) && (idx == 3'd0);
            chk($sformatf("fullscan t=%0d", t), ~one, idx, 1'b0, ef);
        end

        // Masked scan 1000_0101: digits 0,2,7 only
        pos[0] = 3'd0;
        pos[1] = 3'd2;
        pos[2] = 3'd7;
        do_reset();
        for (int t = 0; t < 16; t++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 8'b1000_0101);
            idx = pos[(t / 4) % 3];
            one = 8'b1 << idx;
            ef  = (t % 4 == 0) && (t > 0) && (idx == 3'd0);
            chk($sformatf("maskscan t=%0d", t), ~one, idx, 1'b0, ef);
        end
        // Single-bit mask applied on a tick: jump to 4, then self-wrap frames
        for (int u = 0; u < 13; u++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 8'b0001_0000);
            ef = (u % 4 == 0) && (u > 0);
            chk($sformatf("singlebit u=%0d", u), 8'hEF, 3'd4, 1'b0, ef);
        end

        // Disable mid-scan at digit 2, cnt=1, then restart on lowest mask bit
        do_reset();
        for (int t = 0; t < 10; t++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("pre-disable", 8'hFB, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 8'h28);
        chk("disable", 8'hFF, 3'd2, 1'b1, 1'b0);
        for (int e = 0; e < 4; e++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 8'h28);
            chk($sformatf("restart dwell e=%0d", e), 8'hF7, 3'd3, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h28);
        chk("restart advance", 8'hDF, 3'd5, 1'b0, 1'b0);

        // iEI rising on the wrap tick: no advance, no frame
        do_reset();
        for (int t = 0; t < 32; t++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("pre-collision", 8'h7F, 3'd7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 8'hFF);
        chk("ei on tick", 8'hFF, 3'd7, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("reentry", 8'hFE, 3'd0, 1'b0, 1'b0);

        // Reset on the wrap tick: frame suppressed, outputs blank
        do_reset();
        for (int t = 0; t < 32; t++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("rst on tick", 8'hFF, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("after rst", 8'hFE, 3'd0, 1'b0, 1'b0);

        // Mode change on a tick: direct wins, scan later restarts full dwell
        do_reset();
        for (int t = 0; t < 8; t++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 3'd4, 8'hFF);
        chk("mode on tick", 8'hEF, 3'd4, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
            chk($sformatf("scan back e=%0d", e), 8'hFE, 3'd0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF);
        chk("scan back advance", 8'hFD, 3'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_decoder38_scan
`default_nettype wire
